// File: rtl/bmd_256_latency_reader_pkg.sv
// Shared widths, reset constants and control states for the echo-latency reader.
package bmd_256_latency_reader_pkg;

  localparam int ECHO_TRANS_COUNTER_WIDTH = 40;
  localparam int ADDR_WIDTH               = 13;
  localparam int STAT_COUNT_W             = 32;
  localparam int STAT_SUM_W               = 64;
  localparam int STAT_ERR_W               = 16;

  localparam logic [ECHO_TRANS_COUNTER_WIDTH-1:0] MIN_INIT = '1;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } lat_state_e;

endpackage

// File: rtl/bmd_256_latency_reader_latency_stat_accum.sv
// Running latency statistics: saturating count/err, wrapping sum, min/max.
module latency_stat_accum
  import bmd_256_latency_reader_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic                                valid,
  input  logic                                err,
  input  logic [ECHO_TRANS_COUNTER_WIDTH-1:0] delta,
  output logic [STAT_COUNT_W-1:0]             stat_count,
  output logic [ECHO_TRANS_COUNTER_WIDTH-1:0] stat_min,
  output logic [ECHO_TRANS_COUNTER_WIDTH-1:0] stat_max,
  output logic [STAT_SUM_W-1:0]               stat_sum,
  output logic [STAT_ERR_W-1:0]               stat_err
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      stat_count <= '0;
      stat_min   <= MIN_INIT;
      stat_max   <= '0;
      stat_sum   <= '0;
      stat_err   <= '0;
    end else begin
      if (valid) begin
        if (stat_count != '1)
          stat_count <= stat_count + STAT_COUNT_W'(1);
        stat_sum <= stat_sum + STAT_SUM_W'(delta);
        if (delta < stat_min)
          stat_min <= delta;
        if (delta > stat_max)
          stat_max <= delta;
      end
      if (err && stat_err != '1)
        stat_err <= stat_err + STAT_ERR_W'(1);
    end
  end

endmodule

// File: rtl/bmd_256_latency_reader.sv
// Echo-latency reader: looks up departure timestamps on BRAM port B and
// publishes per-packet latency plus running statistics.
//
// state | meaning
// RUN   | tags accepted, results published
// CLEAR | statistics held at reset, in-flight reads squashed, no tags accepted
module bmd_256_latency_reader
  import bmd_256_latency_reader_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                latency_reset_signal,
  input  logic [ECHO_TRANS_COUNTER_WIDTH-1:0] latency_counter,
  input  logic                                echo_valid,
  input  logic [ADDR_WIDTH-1:0]               echo_tag,
  output logic                                echo_ready,
  output logic                                bram_reb,
  output logic [ADDR_WIDTH-1:0]               bram_rd_addr,
  input  logic [ECHO_TRANS_COUNTER_WIDTH-1:0] bram_rd_data,
  output logic                                lat_valid,
  output logic [ECHO_TRANS_COUNTER_WIDTH-1:0] lat_value,
  output logic [ADDR_WIDTH-1:0]               lat_tag,
  output logic [STAT_COUNT_W-1:0]             stat_count,
  output logic [ECHO_TRANS_COUNTER_WIDTH-1:0] stat_min,
  output logic [ECHO_TRANS_COUNTER_WIDTH-1:0] stat_max,
  output logic [STAT_SUM_W-1:0]               stat_sum,
  output logic [STAT_ERR_W-1:0]               stat_err
);

  lat_state_e                          state;
  logic                                accept;
  logic                                squash;
  logic                                s1_valid, s2_valid;
  logic [ECHO_TRANS_COUNTER_WIDTH-1:0] s1_tarr, s2_tarr;
  logic [ADDR_WIDTH-1:0]               s1_tag, s2_tag;
  logic                                s2_hit;
  logic                                stored_zero;
  logic [ECHO_TRANS_COUNTER_WIDTH-1:0] delta;

  assign accept       = echo_valid && echo_ready;
  assign bram_reb     = accept;
  assign bram_rd_addr = accept ? echo_tag : '0;

  // A clear request squashes in the very cycle it rises, so it beats a completing read.
  assign squash = latency_reset_signal || (state == CLEAR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      echo_ready <= 1'b0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_tarr    <= '0;
      s2_tarr    <= '0;
      s1_tag     <= '0;
      s2_tag     <= '0;
    end else begin
      case (state)
        RUN:     if (latency_reset_signal)  state <= CLEAR;
        CLEAR:   if (!latency_reset_signal) state <= RUN;
        default: state <= RUN;
      endcase
      echo_ready <= !latency_reset_signal;
      s1_valid   <= accept && !squash;
      s2_valid   <= s1_valid && !squash;
      if (accept) begin
        s1_tarr <= latency_counter;
        s1_tag  <= echo_tag;
      end
      s2_tarr <= s1_tarr;
      s2_tag  <= s1_tag;
    end
  end

  // Modular subtraction keeps wrapped counters correct for any latency below 2^40.
  assign s2_hit      = s2_valid && !squash;
  assign stored_zero = (bram_rd_data == '0);
  assign delta       = s2_tarr - bram_rd_data;

  assign lat_valid = s2_hit && !stored_zero;
  assign lat_value = lat_valid ? delta  : '0;
  assign lat_tag   = lat_valid ? s2_tag : '0;

  latency_stat_accum u_stat (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (squash),
    .valid      (lat_valid),
    .err        (s2_hit && stored_zero),
    .delta      (delta),
    .stat_count (stat_count),
    .stat_min   (stat_min),
    .stat_max   (stat_max),
    .stat_sum   (stat_sum),
    .stat_err   (stat_err)
  );

endmodule
